// File: rtl/ro_puf_pkg.sv
// Shared types, default constants and the oscillator pair-select helper
// for the ring-oscillator PUF sequencer.
package ro_puf_pkg;

  localparam int N_BITS_DEF        = 8;
  localparam int CNT_W_DEF         = 16;
  localparam int WIN_CYCLES_DEF    = 1024;
  localparam int SETTLE_CYCLES_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_COMPARE,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
  } sel_pair_t;

  // Offsets both bases by k with 4-bit wrap; a coincident pair would compare an
  // oscillator with itself, so bank B is bumped to the next index.
  function automatic sel_pair_t pair_select(input logic [3:0] base_a,
                                            input logic [3:0] base_b,
                                            input logic [3:0] k);
    sel_pair_t p;
    p.a = base_a + k;
    p.b = base_b + k;
    if (p.a == p.b) p.b = p.a + 4'd1;
    return p;
  endfunction

endpackage

// File: rtl/ro_puf_ctrl_if.sv
// Host-side request/response bundle of the RO PUF sequencer.
interface ro_puf_ctrl_if #(
  parameter int N_BITS = ro_puf_pkg::N_BITS_DEF
);
  logic              start;
  logic [7:0]        challenge;
  logic              busy;
  logic [N_BITS-1:0] resp;
  logic              resp_valid;
  logic              resp_ready;
  logic              tie;

  modport master (
    output start, challenge, resp_ready,
    input  busy, resp, resp_valid, tie
  );

  modport slave (
    input  start, challenge, resp_ready,
    output busy, resp, resp_valid, tie
  );
endinterface

// File: rtl/ro_puf_win_timer.sv
// Loadable down-counter timing the CLEAR, RUN and SETTLE phases.
// A phase of D cycles is loaded with D-1; expire is high on its last cycle.
module ro_puf_win_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) count_d = value;
    else if (count_q != '0) count_d = count_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign expire = (count_q == '0);

endmodule

// File: rtl/ro_puf_ctrl.sv
// RO PUF sequencer: per response bit clears, runs, settles and compares an
// oscillator pair. Define RO_PUF_MAJORITY_EN for 3-measurement majority voting.
module ro_puf_ctrl
  import ro_puf_pkg::*;
#(
  parameter int N_BITS        = N_BITS_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int WIN_CYCLES    = WIN_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  ro_puf_ctrl_if.slave     host,
  input  logic [CNT_W-1:0] cnt_a,
  input  logic [CNT_W-1:0] cnt_b,
  output logic             osc_en,
  output logic             cnt_clr,
  output logic [3:0]       sel_a,
  output logic [3:0]       sel_b
);

  localparam int TMAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] CLR_LD = TW'(1);
  localparam logic [TW-1:0] WIN_LD = TW'(WIN_CYCLES - 1);
  localparam logic [TW-1:0] SET_LD = TW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    K_LAST = 4'(N_BITS - 1);

  state_e            state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic [7:0]        chal_q, chal_d;
  logic [N_BITS-1:0] resp_q, resp_d;
  logic              tie_q, tie_d;
  logic              osc_en_q, osc_en_d;
  logic              cnt_clr_q, cnt_clr_d;
  logic              busy_q, busy_d;
  logic              resp_valid_q, resp_valid_d;
  logic [3:0]        sel_a_q, sel_a_d;
  logic [3:0]        sel_b_q, sel_b_d;
`ifdef RO_PUF_MAJORITY_EN
  logic [1:0]        meas_q, meas_d;
  logic [1:0]        votes_q, votes_d;
`endif

  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_expire;
  logic          cmp_gt, cmp_eq;
  logic          bit_done, bit_val;
  sel_pair_t     pair;

  ro_puf_win_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .value  (tmr_value),
    .expire (tmr_expire)
  );

  assign cmp_gt = (cnt_a > cnt_b);
  assign cmp_eq = (cnt_a == cnt_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      chal_q       <= '0;
      resp_q       <= '0;
      tie_q        <= 1'b0;
      osc_en_q     <= 1'b0;
      cnt_clr_q    <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      sel_a_q      <= '0;
      sel_b_q      <= '0;
`ifdef RO_PUF_MAJORITY_EN
      meas_q       <= '0;
      votes_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      chal_q       <= chal_d;
      resp_q       <= resp_d;
      tie_q        <= tie_d;
      osc_en_q     <= osc_en_d;
      cnt_clr_q    <= cnt_clr_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      sel_a_q      <= sel_a_d;
      sel_b_q      <= sel_b_d;
`ifdef RO_PUF_MAJORITY_EN
      meas_q       <= meas_d;
      votes_q      <= votes_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    chal_d    = chal_q;
    resp_d    = resp_q;
    tie_d     = tie_q;
    tmr_load  = 1'b0;
    tmr_value = CLR_LD;
    bit_done  = 1'b0;
    bit_val   = 1'b0;
`ifdef RO_PUF_MAJORITY_EN
    meas_d    = meas_q;
    votes_d   = votes_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (host.start) begin
          state_d  = S_CLEAR;
          chal_d   = host.challenge;
          resp_d   = '0;
          tie_d    = 1'b0;
          k_d      = '0;
          tmr_load = 1'b1;
`ifdef RO_PUF_MAJORITY_EN
          meas_d   = '0;
          votes_d  = '0;
`endif
        end
      end
      S_CLEAR: begin
        if (tmr_expire) begin
          state_d   = S_RUN;
          tmr_load  = 1'b1;
          tmr_value = WIN_LD;
        end
      end
      S_RUN: begin
        if (tmr_expire) begin
          state_d   = S_SETTLE;
          tmr_load  = 1'b1;
          tmr_value = SET_LD;
        end
      end
      S_SETTLE: begin
        if (tmr_expire) state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (cmp_eq) tie_d = 1'b1;
`ifdef RO_PUF_MAJORITY_EN
        // The first two votes are only tallied; the third resolves the bit.
        if (meas_q != 2'd2) begin
          meas_d   = meas_q + 2'd1;
          votes_d  = votes_q + {1'b0, cmp_gt};
          state_d  = S_CLEAR;
          tmr_load = 1'b1;
        end else begin
          bit_done = 1'b1;
          bit_val  = (votes_q == 2'd2) || ((votes_q == 2'd1) && cmp_gt);
          meas_d   = '0;
          votes_d  = '0;
        end
`else
        bit_done = 1'b1;
        bit_val  = cmp_gt;
`endif
        if (bit_done) begin
          resp_d = resp_q | (N_BITS'(bit_val) << k_q);
          if (k_q == K_LAST) begin
            state_d = S_DONE;
          end else begin
            k_d      = k_q + 4'd1;
            state_d  = S_CLEAR;
            tmr_load = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (host.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    osc_en_d     = (state_d == S_RUN);
    cnt_clr_d    = (state_d == S_CLEAR);
    busy_d       = (state_d != S_IDLE);
    resp_valid_d = (state_d == S_DONE);
    pair         = pair_select(chal_d[3:0], chal_d[7:4], k_d);
    sel_a_d      = sel_a_q;
    sel_b_d      = sel_b_q;
    if (state_d == S_CLEAR) begin
      sel_a_d = pair.a;
      sel_b_d = pair.b;
    end
  end

  assign osc_en          = osc_en_q;
  assign cnt_clr         = cnt_clr_q;
  assign sel_a           = sel_a_q;
  assign sel_b           = sel_b_q;
  assign host.busy       = busy_q;
  assign host.resp       = resp_q;
  assign host.resp_valid = resp_valid_q;
  assign host.tie        = tie_q;

endmodule
